// File: rtl/pwm_cmp_dt_tx.sv
// pwm_cmp_dt_tx
// Complementary PWM generator for a power stage: the primary switch (pwm_out)
// and the synchronous-rectifier switch (secondary_out) are separated by a
// programmable dead time at both transitions. Period, on-time and dead time
// are double-buffered and take effect at a period boundary only. A soft-start
// ramp limits the on-time after every enable, and a latched fault state forces
// both gates low until it is explicitly cleared.
//
// Strobe semantics: pwm_chg and fault_clr are single-cycle strobes with no
// back-pressure. They are sampled on the rising clock edge they are high for
// and are always accepted. No ready signal exists, so a strobe is never
// stalled or lost.
module pwm_cmp_dt_tx #(
  parameter int CNT_WIDTH  = 16,
  parameter int SS_START   = 8,
  parameter int SS_STEP    = 4,
  parameter int MIN_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 pwm_chg,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [CNT_WIDTH-1:0] on_in,
  input  logic [CNT_WIDTH-1:0] dead_in,
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic                 pwm_out,
  output logic                 secondary_out,
  output logic                 period_start,
  output logic                 fault_flag,
  output logic [1:0]           state
);

  localparam logic [CNT_WIDTH-1:0] MIN_PER  = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] SS_INIT  = CNT_WIDTH'(SS_START);
  localparam logic [CNT_WIDTH-1:0] SS_INC   = CNT_WIDTH'(SS_STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOFT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Shadow (written by pwm_chg) and active (used by the counter) settings
  logic [CNT_WIDTH-1:0] sh_per;
  logic [CNT_WIDTH-1:0] sh_on;
  logic [CNT_WIDTH-1:0] sh_dead;
  logic                 pend;
  logic [CNT_WIDTH-1:0] act_per;
  logic [CNT_WIDTH-1:0] act_on;
  logic [CNT_WIDTH-1:0] act_dead;

  // Period counter and soft-start limit
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] ss_lim;
  logic [CNT_WIDTH:0]   ss_sum;
  logic [CNT_WIDTH-1:0] ss_next;

  // Decode intermediates, one bit wider so dead-time arithmetic cannot wrap
  logic [CNT_WIDTH:0]   per_w;
  logic [CNT_WIDTH:0]   dead2_w;
  logic [CNT_WIDTH:0]   lim_w;
  logic [CNT_WIDTH-1:0] on_eff;
  logic [CNT_WIDTH:0]   sec_lo_w;
  logic [CNT_WIDTH:0]   cnt_dead_w;
  logic                 pwm_d;
  logic                 sec_d;

  logic running;
  logic run_next;
  logic boundary;

  assign running  = (state_q == ST_SOFT) || (state_q == ST_RUN);
  assign run_next = (state_d == ST_SOFT) || (state_d == ST_RUN);
  assign boundary = running && (cnt == (act_per - CNT_ONE));

  assign state        = state_q;
  assign fault_flag   = (state_q == ST_FAULT);
  assign period_start = running && (cnt == CNT_ZERO);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fault overrides every other condition
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_SOFT;
        end
        ST_SOFT: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (boundary && (ss_lim >= act_on)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shadow capture on pwm_chg; pend remembers an unapplied update. A strobe in
  // the boundary cycle re-arms pend, so it is applied at the next boundary.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sh_per  <= MIN_PER;
      sh_on   <= '0;
      sh_dead <= '0;
      pend    <= 1'b0;
    end else begin
      if (pwm_chg) begin
        sh_per  <= (period_in < MIN_PER) ? MIN_PER : period_in;
        sh_on   <= on_in;
        sh_dead <= dead_in;
        pend    <= 1'b1;
      end else if ((state_q == ST_IDLE) || (boundary && pend)) begin
        pend    <= 1'b0;
      end
    end
  end

  // Active settings follow the shadow freely in IDLE, otherwise only at a boundary
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_per  <= MIN_PER;
      act_on   <= '0;
      act_dead <= '0;
    end else if ((state_q == ST_IDLE) || (boundary && pend)) begin
      act_per  <= sh_per;
      act_on   <= sh_on;
      act_dead <= sh_dead;
    end
  end

  // Saturating soft-start increment
  always_comb begin
    ss_sum  = {1'b0, ss_lim} + {1'b0, SS_INC};
    ss_next = ss_sum[CNT_WIDTH] ? '1 : ss_sum[CNT_WIDTH-1:0];
  end

  // Period counter: free-running while active, parked at 0 otherwise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (running && run_next) begin
      cnt <= boundary ? CNT_ZERO : (cnt + CNT_ONE);
    end else begin
      cnt <= '0;
    end
  end

  // Soft-start limit: reloaded on enable, stepped once per SOFT period
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ss_lim <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_SOFT)) begin
      ss_lim <= SS_INIT;
    end else if ((state_q == ST_SOFT) && boundary) begin
      ss_lim <= ss_next;
    end
  end

  // Largest on-time that still leaves a dead time at both edges
  always_comb begin
    per_w   = {1'b0, act_per};
    dead2_w = {act_dead, 1'b0};
    lim_w   = '0;
    if (dead2_w < per_w) lim_w = per_w - dead2_w;
  end

  // Effective on-time: request, clamped by the dead-time limit and the soft-start ramp
  always_comb begin
    on_eff = act_on;
    if (lim_w < {1'b0, act_on}) on_eff = lim_w[CNT_WIDTH-1:0];
    if ((state_q == ST_SOFT) && (ss_lim < on_eff)) on_eff = ss_lim;
  end

  // Gate decode from the current count; the secondary window starts one dead
  // time after the primary falls and ends one dead time before the period wraps
  always_comb begin
    sec_lo_w   = {1'b0, on_eff} + {1'b0, act_dead};
    cnt_dead_w = {1'b0, cnt} + {1'b0, act_dead};
    pwm_d      = (cnt < on_eff) && (on_eff != CNT_ZERO);
    sec_d      = ({1'b0, cnt} >= sec_lo_w) && (cnt_dead_w < per_w);
  end

  // Registered gate drives; forced low on the edge that leaves SOFT/RUN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pwm_out       <= 1'b0;
      secondary_out <= 1'b0;
    end else if (running && run_next) begin
      pwm_out       <= pwm_d;
      secondary_out <= sec_d;
    end else begin
      pwm_out       <= 1'b0;
      secondary_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_cmp_dt_tx.sv
// Testbench for pwm_cmp_dt_tx: a cycle reference model built from the
// period/on/dead rules in integer arithmetic feeds an expected queue that is
// checked every clock, plus a table of steady-state pulse widths and directed
// sequences for double buffering, soft start, fault and async reset.
module tb_pwm_cmp_dt_tx;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic        pwm_chg;
  logic [15:0] period_in;
  logic [15:0] on_in;
  logic [15:0] dead_in;
  logic        fault;
  logic        fault_clr;
  logic        pwm_out;
  logic        secondary_out;
  logic        period_start;
  logic        fault_flag;
  logic [1:0]  state;

  pwm_cmp_dt_tx dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .en            (en),
    .pwm_chg       (pwm_chg),
    .period_in     (period_in),
    .on_in         (on_in),
    .dead_in       (dead_in),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .pwm_out       (pwm_out),
    .secondary_out (secondary_out),
    .period_start  (period_start),
    .fault_flag    (fault_flag),
    .state         (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 soft, 2 run, 3 fault; m_pos: position in period
  int m_st, m_pos, m_ss, m_pend;
  int m_per, m_on, m_dead;
  int s_per, s_on, s_dead;
  bit m_pwm, m_sec;

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_ss = 0; m_pend = 0;
    m_per = 4; m_on = 0; m_dead = 0;
    s_per = 4; s_on = 0; s_dead = 0;
    m_pwm = 0; m_sec = 0;
  endtask

  task automatic model_step();
    int nst, lim, oe;
    bit run, nrun, bnd;
    logic [5:0] e;
    if (!n_rst) begin
      model_reset();
    end else begin
      run = (m_st == 1) || (m_st == 2);
      bnd = run && (m_pos == m_per - 1);
      if (fault) nst = 3;
      else begin
        case (m_st)
          0: nst = en ? 1 : 0;
          1: nst = !en ? 0 : ((bnd && m_ss >= m_on) ? 2 : 1);
          2: nst = en ? 2 : 0;
          default: nst = fault_clr ? 0 : 3;
        endcase
      end
      nrun = (nst == 1) || (nst == 2);
      lim = m_per - 2 * m_dead;
      if (lim < 0) lim = 0;
      oe = (m_on < lim) ? m_on : lim;
      if (m_st == 1 && m_ss < oe) oe = m_ss;
      m_pwm = 0;
      m_sec = 0;
      if (run && nrun) begin
        m_pwm = (m_pos < oe);
        m_sec = (m_pos >= oe + m_dead) && (m_pos < m_per - m_dead);
      end
      if (m_st == 0 && nst == 1) m_ss = 8;
      else if (m_st == 1 && bnd) m_ss = (m_ss + 4 > 65535) ? 65535 : m_ss + 4;
      m_pos = (run && nrun) ? (bnd ? 0 : m_pos + 1) : 0;
      if (m_st == 0 || (bnd && m_pend != 0)) begin
        m_per = s_per; m_on = s_on; m_dead = s_dead; m_pend = 0;
      end
      if (pwm_chg) begin
        s_per  = (int'(period_in) < 4) ? 4 : int'(period_in);
        s_on   = int'(on_in);
        s_dead = int'(dead_in);
        m_pend = 1;
      end
      m_st = nst;
    end
    e = {m_st[1:0], (m_st == 3), ((m_st == 1 || m_st == 2) && m_pos == 0), m_sec, m_pwm};
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [5:0] got;
    logic [5:0] exp;
    @(posedge clk);
    model_step();
    #1;
    got = {state, fault_flag, period_start, secondary_out, pwm_out};
    exp = exp_q.pop_front();
    check("cycle_outputs{state,ff,ps,sec,pwm}", {26'd0, got}, {26'd0, exp});
  endtask

  task automatic set_cfg(input int p, input int o, input int d);
    period_in = 16'(p);
    on_in     = 16'(o);
    dead_in   = 16'(d);
    pwm_chg   = 1'b1;
    tick();
    pwm_chg   = 1'b0;
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 3000; i++) begin
      if (period_start) break;
      tick();
    end
    check("period_start_seen", {31'd0, period_start}, 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] st);
    for (int i = 0; i < 20000; i++) begin
      if (state == st) break;
      tick();
    end
    check("reach_state", {30'd0, state}, {30'd0, st});
  endtask

  task automatic measure(input int per, output int hi, output int sh, output int both);
    hi = 0; sh = 0; both = 0;
    for (int i = 0; i < per; i++) begin
      tick();
      if (pwm_out) hi++;
      if (secondary_out) sh++;
      if (pwm_out && secondary_out) both++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int per;
    int on;
    int dead;
    int exp_hi;
    int exp_sec;
  } vec_t;

  vec_t vecs[7];
  int hi, sh, both, rest;

  initial begin
    vecs[0] = '{per: 40,  on: 35,  dead: 10, exp_hi: 20,  exp_sec: 0};
    vecs[1] = '{per: 10,  on: 5,   dead: 6,  exp_hi: 0,   exp_sec: 0};
    vecs[2] = '{per: 20,  on: 5,   dead: 0,  exp_hi: 5,   exp_sec: 15};
    vecs[3] = '{per: 2,   on: 1,   dead: 0,  exp_hi: 1,   exp_sec: 3};
    vecs[4] = '{per: 8,   on: 20,  dead: 1,  exp_hi: 6,   exp_sec: 0};
    vecs[5] = '{per: 100, on: 0,   dead: 5,  exp_hi: 0,   exp_sec: 90};
    vecs[6] = '{per: 400, on: 100, dead: 10, exp_hi: 100, exp_sec: 280};

    // reset
    n_rst = 1'b0; en = 1'b0; pwm_chg = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    period_in = '0; on_in = '0; dead_in = '0;
    model_reset();
    repeat (3) tick();
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_outputs", {28'd0, pwm_out, secondary_out, period_start, fault_flag}, 32'd0);
    n_rst = 1'b1;
    tick();

    // steady-state widths per table entry
    for (int v = 0; v < 7; v++) begin
      en = 1'b0;
      repeat (2) tick();
      set_cfg(vecs[v].per, vecs[v].on, vecs[v].dead);
      en = 1'b1;
      wait_state(2'd2);
      wait_ps();
      measure((vecs[v].per < 4) ? 4 : vecs[v].per, hi, sh, both);
      check("table_pwm_width", hi, vecs[v].exp_hi);
      check("table_sec_width", sh, vecs[v].exp_sec);
      check("table_no_overlap", both, 0);
    end

    // double buffering: change on-time mid-period (now in RUN 400/100/10, cnt=0)
    repeat (50) tick();
    set_cfg(400, 200, 10);
    rest = pwm_out ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      if (period_start) break;
      tick();
      if (pwm_out) rest++;
    end
    check("dbuf_current_period_rest", rest, 50);
    measure(400, hi, sh, both);
    check("dbuf_next_pwm", hi, 200);
    check("dbuf_next_sec", sh, 180);

    // soft-start ramp 8,12,..,100
    en = 1'b0;
    repeat (2) tick();
    set_cfg(400, 100, 10);
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      wait_ps();
      measure(400, hi, sh, both);
      check("ss_width", hi, 8 + 4 * k);
      check("ss_state", {30'd0, state}, (k < 23) ? 32'd1 : 32'd2);
    end

    // fault at cnt=30, en ignored, clear only with fault low
    repeat (30) tick();
    check("pre_fault_pwm_high", {31'd0, pwm_out}, 32'd1);
    fault = 1'b1;
    tick();
    check("fault_outputs", {29'd0, fault_flag, pwm_out, secondary_out}, 32'b100);
    for (int i = 0; i < 6; i++) begin
      en = ~en;
      tick();
      check("fault_en_ignored", {30'd0, state}, 32'd3);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_clr_blocked", {30'd0, state}, 32'd3);
    fault = 1'b0;
    tick();
    check("fault_latched", {30'd0, state}, 32'd3);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_to_idle", {30'd0, state}, 32'd0);
    tick();
    check("reenable_via_soft", {30'd0, state}, 32'd1);

    // async reset mid-RUN
    wait_state(2'd2);
    repeat (17) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset_outputs", {29'd0, pwm_out, secondary_out, period_start}, 32'd0);
    check("async_reset_state", {30'd0, state}, 32'd0);
    model_reset();
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    check("post_reset_soft", {30'd0, state}, 32'd1);
    wait_state(2'd2);
    wait_ps();
    measure(4, hi, sh, both);
    check("default_pwm", hi, 0);
    check("default_sec", sh, 4);
    set_cfg(20, 5, 0);
    tick();
    wait_ps();
    measure(20, hi, sh, both);
    check("post_reset_cfg_pwm", hi, 5);
    check("post_reset_cfg_sec", sh, 15);

    // randomized stimulus against the model
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      if (!fault && $urandom_range(0, 299) == 0) fault = 1'b1;
      else if (fault && $urandom_range(0, 15) == 0) fault = 1'b0;
      fault_clr = ($urandom_range(0, 7) == 0);
      pwm_chg   = ($urandom_range(0, 24) == 0);
      period_in = 16'($urandom_range(0, 40));
      on_in     = 16'($urandom_range(0, 45));
      dead_in   = 16'($urandom_range(0, 12));
      tick();
    end
    pwm_chg = 1'b0;
    fault_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
